// File: rtl/bomb_game_ctrl_if.sv
// Board/display-side signal bundle for bomb_game_ctrl.
// master: the controller; slave: the board switches and display block.
// Optional macro BOMB_STRIKE_EN adds the strike indicator.
interface bomb_game_ctrl_if #(
    parameter int NWIRE = 4
) ();
    localparam int KW = $clog2(NWIRE);

    logic             power_sw;
    logic             start_btn;
    logic [NWIRE-1:0] wire_cut;
    logic [KW-1:0]    key_idx;
    logic             fail_in;
    logic             disp_en;
    logic             fuse_run;
    logic             disp_clr;
    logic             defused;
    logic             exploded;
    logic [3:0]       score;
    logic [2:0]       state;
`ifdef BOMB_STRIKE_EN
    logic             strike;
`endif

    modport master (
        input  power_sw, start_btn, wire_cut, key_idx, fail_in,
`ifdef BOMB_STRIKE_EN
        output strike,
`endif
        output disp_en, fuse_run, disp_clr, defused, exploded, score, state
    );

    modport slave (
        output power_sw, start_btn, wire_cut, key_idx, fail_in,
`ifdef BOMB_STRIKE_EN
        input  strike,
`endif
        input  disp_en, fuse_run, disp_clr, defused, exploded, score, state
    );
endinterface

// File: rtl/bomb_game_ctrl.sv
// Game sequencer for the bomb dot-matrix display: power gating, arming,
// wire-cut / fuse-fail watch and defused/exploded outcome with a hold time.
// Optional macro BOMB_STRIKE_EN: first wrong cut gives a strike, second explodes.
//
// state   | meaning
// --------+-----------------------------------------------
// OFF     | power switch off, display disabled
// IDLE    | display on, waiting for a debounced start
// ARM     | one cycle: clear display, latch the key wire
// RUN     | fuse burning, watching cuts and fail flag
// DEFUSED | correct wire cut; hold, then wait for wires restored
// BOOM    | wrong wire or fuse burnt; hold, then wait for wires restored
module bomb_game_ctrl #(
    parameter int NWIRE    = 4,
    parameter int DEB_CYC  = 16,
    parameter int HOLD_CYC = 200
) (
    input  logic              clk,
    input  logic              rst,
    bomb_game_ctrl_if.master  bus
);
    localparam int KW = $clog2(NWIRE);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_IDLE    = 3'd1,
        S_ARM     = 3'd2,
        S_RUN     = 3'd3,
        S_DEFUSED = 3'd4,
        S_BOOM    = 3'd5
    } state_t;

    state_t           state_q, state_nx;
    logic             power_s1, power_s;
    logic             btn_s1, btn_s;
    logic [NWIRE-1:0] cut_s1, cut_s;
    logic [DW-1:0]    deb_cnt;
    logic             btn_lvl;
    logic             start_p;
    logic             fail_q;
    logic             fail_rise;
    logic [KW-1:0]    key_q;
    logic [HW-1:0]    hold_q;
    logic [3:0]       score_q;
    logic [NWIRE-1:0] key_oh;
    logic             cut_key;
    logic             cut_bad;
`ifdef BOMB_STRIKE_EN
    logic             strike_q;
    logic             strike_set;
    logic [NWIRE-1:0] mask_q;
`endif

    assign fail_rise = bus.fail_in & ~fail_q;
    assign key_oh    = NWIRE'(1) << key_q;
    assign cut_key   = cut_s[key_q];
`ifdef BOMB_STRIKE_EN
    assign cut_bad   = |(cut_s & ~key_oh & ~mask_q);
`else
    assign cut_bad   = |(cut_s & ~key_oh);
`endif

    // Two-stage synchronizers for the board inputs, plus fail_in history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_s1 <= 1'b0;
            power_s  <= 1'b0;
            btn_s1   <= 1'b0;
            btn_s    <= 1'b0;
            cut_s1   <= '0;
            cut_s    <= '0;
            fail_q   <= 1'b0;
        end else begin
            power_s1 <= bus.power_sw;
            power_s  <= power_s1;
            btn_s1   <= bus.start_btn;
            btn_s    <= btn_s1;
            cut_s1   <= bus.wire_cut;
            cut_s    <= cut_s1;
            fail_q   <= bus.fail_in;
        end
    end

    // Debounce: accept a new button level after DEB_CYC consecutive differing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt <= '0;
            btn_lvl <= 1'b0;
            start_p <= 1'b0;
        end else begin
            start_p <= 1'b0;
            if (btn_s == btn_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
                deb_cnt <= '0;
                btn_lvl <= btn_s;
                start_p <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_OFF;
        else      state_q <= state_nx;
    end

    // Next-state logic; power-off overrides every other transition.
    always_comb begin
        state_nx = state_q;
`ifdef BOMB_STRIKE_EN
        strike_set = 1'b0;
`endif
        case (state_q)
            S_OFF:   if (power_s) state_nx = S_IDLE;
            S_IDLE:  if (start_p && (cut_s == '0)) state_nx = S_ARM;
            S_ARM:   state_nx = S_RUN;
            S_RUN: begin
`ifdef BOMB_STRIKE_EN
                if (fail_rise || (cut_bad && strike_q)) state_nx = S_BOOM;
                else if (cut_bad)                       strike_set = 1'b1;
                else if (cut_key)                       state_nx = S_DEFUSED;
`else
                if (fail_rise || cut_bad) state_nx = S_BOOM;
                else if (cut_key)         state_nx = S_DEFUSED;
`endif
            end
            S_DEFUSED, S_BOOM:
                if ((hold_q == '0) && (cut_s == '0)) state_nx = S_IDLE;
            default: state_nx = S_OFF;
        endcase
        if (!power_s) state_nx = S_OFF;
    end

    // Round datapath: key latch, result hold timer, score, strike tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q   <= '0;
            hold_q  <= '0;
            score_q <= '0;
`ifdef BOMB_STRIKE_EN
            strike_q <= 1'b0;
            mask_q   <= '0;
`endif
        end else begin
            if (state_q == S_ARM) key_q <= bus.key_idx;
            if ((state_q == S_RUN) && ((state_nx == S_DEFUSED) || (state_nx == S_BOOM)))
                hold_q <= HW'(HOLD_CYC - 1);
            else if (hold_q != '0)
                hold_q <= hold_q - 1'b1;
            if ((state_q == S_RUN) && (state_nx == S_DEFUSED) && (score_q != 4'd15))
                score_q <= score_q + 1'b1;
`ifdef BOMB_STRIKE_EN
            if ((state_q == S_ARM) || (state_q == S_OFF)) begin
                strike_q <= 1'b0;
                mask_q   <= '0;
            end else if (strike_set) begin
                strike_q <= 1'b1;
                mask_q   <= mask_q | (cut_s & ~key_oh);
            end
`endif
        end
    end

    // Output decode from the state register only.
    always_comb begin
        bus.disp_en  = 1'b0;
        bus.fuse_run = 1'b0;
        bus.disp_clr = 1'b0;
        bus.defused  = 1'b0;
        bus.exploded = 1'b0;
        case (state_q)
            S_IDLE:    bus.disp_en = 1'b1;
            S_ARM: begin
                bus.disp_en  = 1'b1;
                bus.disp_clr = 1'b1;
            end
            S_RUN: begin
                bus.disp_en  = 1'b1;
                bus.fuse_run = 1'b1;
            end
            S_DEFUSED: begin
                bus.disp_en = 1'b1;
                bus.defused = 1'b1;
            end
            S_BOOM: begin
                bus.disp_en  = 1'b1;
                bus.exploded = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.score = score_q;
    assign bus.state = state_q;
`ifdef BOMB_STRIKE_EN
    assign bus.strike = strike_q;
`endif
endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Scoreboard bench for bomb_game_ctrl: stimulus pushes the expected output
// snapshot of every state change; the monitor pops one per observed change.
module tb_bomb_game_ctrl;
    localparam logic [2:0] OFF = 3'd0, IDLE = 3'd1, ARM = 3'd2, RUN = 3'd3,
                           DEF = 3'd4, BOOM = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bomb_game_ctrl_if #(.NWIRE(4)) bus ();

    bomb_game_ctrl #(.NWIRE(4), .DEB_CYC(16), .HOLD_CYC(200)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] st;
        logic       en, fr, clr, df, ex;
        logic [3:0] sc;
        int         lat;   // edges since stimulus stamp, -1 = don't care
        int         gap;   // edges since previous state change, -1 = don't care
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         stamp = 0;
    int         last_evt = 0;
    logic [3:0] exp_score = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the debug state is an output event.
    initial begin : monitor
        logic [2:0] prev_st;
        exp_t e;
        prev_st = 3'd7;
        forever begin
            @(negedge clk);
            if (bus.state !== prev_st) begin
                prev_st = bus.state;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: state=%0d at cycle %0d, none expected", bus.state, cyc);
                end else begin
                    e = q.pop_front();
                    if ({bus.state, bus.disp_en, bus.fuse_run, bus.disp_clr, bus.defused, bus.exploded, bus.score}
                        !== {e.st, e.en, e.fr, e.clr, e.df, e.ex, e.sc}) begin
                        errors++;
                        $display("FAIL outputs: got st=%0d en=%b fr=%b clr=%b df=%b ex=%b sc=%0d, expected st=%0d en=%b fr=%b clr=%b df=%b ex=%b sc=%0d",
                                 bus.state, bus.disp_en, bus.fuse_run, bus.disp_clr, bus.defused, bus.exploded, bus.score,
                                 e.st, e.en, e.fr, e.clr, e.df, e.ex, e.sc);
                    end
                    if (e.lat >= 0) begin
                        checks++;
                        if (cyc - stamp != e.lat) begin
                            errors++;
                            $display("FAIL latency st=%0d: got %0d edges, expected %0d", e.st, cyc - stamp, e.lat);
                        end
                    end
                    if (e.gap >= 0) begin
                        checks++;
                        if (cyc - last_evt != e.gap) begin
                            errors++;
                            $display("FAIL dwell st=%0d: got %0d edges, expected %0d", e.st, cyc - last_evt, e.gap);
                        end
                    end
                end
                last_evt = cyc;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [2:0] st, input logic en, input logic fr, input logic clr,
                        input logic df, input logic ex, input logic [3:0] sc,
                        input int lat, input int gap);
        exp_t e;
        e.st = st; e.en = en; e.fr = fr; e.clr = clr; e.df = df; e.ex = ex;
        e.sc = sc; e.lat = lat; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout_%s: %0d expected events still pending after %0d cycles, expected 0",
                     name, q.size(), budget);
            q.delete();
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Press start long enough to be accepted; expect ARM for one edge, then RUN.
    task automatic arm(input logic [1:0] key, input logic [3:0] sc);
        @(negedge clk);
        bus.key_idx = key;
        push(ARM, 1, 0, 1, 0, 0, sc, -1, -1);
        push(RUN, 1, 1, 0, 0, 0, sc, -1, 1);
        bus.start_btn = 1'b1;
        waitn(24);
        bus.start_btn = 1'b0;
        drain(60, "arm");
        waitn(24);
    endtask

    initial begin : stimulus
        bus.power_sw  = 1'b0;
        bus.start_btn = 1'b0;
        bus.wire_cut  = 4'b0000;
        bus.key_idx   = 2'd0;
        bus.fail_in   = 1'b0;
        rst = 1'b0;

        // Reset state
        push(OFF, 0, 0, 0, 0, 0, 4'd0, -1, -1);
        waitn(3);
        rst = 1'b1;
        drain(5, "reset");

        // Power on
        @(negedge clk);
        bus.power_sw = 1'b1; stamp = cyc;
        push(IDLE, 1, 0, 0, 0, 0, 4'd0, 3, -1);
        drain(10, "power_on");

        // Short bounce: no transition
        @(negedge clk);
        bus.start_btn = 1'b1;
        waitn(10);
        bus.start_btn = 1'b0;
        waitn(30);

        // Arm and defuse with the correct wire
        arm(2'd2, exp_score);
        @(negedge clk);
        bus.wire_cut = 4'b0100; stamp = cyc;
        exp_score = 4'd1;
        push(DEF, 1, 0, 0, 1, 0, exp_score, 3, -1);
        drain(10, "defuse");
        waitn(10);
        bus.wire_cut = 4'b0000;
        push(IDLE, 1, 0, 0, 0, 0, exp_score, -1, 200);
        drain(300, "defuse_hold");

        // Correct and wrong wire together
        arm(2'd2, exp_score);
        @(negedge clk);
        bus.wire_cut = 4'b0101; stamp = cyc;
`ifdef BOMB_STRIKE_EN
        exp_score = 4'd2;
        push(DEF, 1, 0, 0, 1, 0, exp_score, 4, -1);
`else
        push(BOOM, 1, 0, 0, 0, 1, exp_score, 3, -1);
`endif
        drain(10, "double_cut");
        waitn(250);
        bus.wire_cut = 4'b0000; stamp = cyc;
        push(IDLE, 1, 0, 0, 0, 0, exp_score, 3, -1);
        drain(10, "restore");

        // Fuse burnt with no cut
        arm(2'd1, exp_score);
        @(negedge clk);
        bus.fail_in = 1'b1; stamp = cyc;
        push(BOOM, 1, 0, 0, 0, 1, exp_score, 1, -1);
        drain(5, "fail_rise");
        push(IDLE, 1, 0, 0, 0, 0, exp_score, -1, 200);
        drain(260, "boom_hold");

        // fail_in still high on re-entry is not a rise; then power off mid-RUN
        arm(2'd1, exp_score);
        waitn(10);
        @(negedge clk);
        bus.power_sw = 1'b0; stamp = cyc;
        push(OFF, 0, 0, 0, 0, 0, exp_score, 3, -1);
        drain(10, "power_off");
        bus.fail_in = 1'b0;

        // Power back on; start with a wire cut is ignored
        @(negedge clk);
        bus.power_sw = 1'b1; stamp = cyc;
        push(IDLE, 1, 0, 0, 0, 0, exp_score, 3, -1);
        drain(10, "power_on2");
        bus.wire_cut = 4'b0001;
        waitn(3);
        bus.start_btn = 1'b1;
        waitn(24);
        bus.start_btn = 1'b0;
        waitn(30);
        bus.wire_cut = 4'b0000;
        waitn(5);

`ifdef BOMB_STRIKE_EN
        // Strike: first wrong cut tolerated, second explodes, re-arm clears
        arm(2'd0, exp_score);
        chk("strike_after_arm", int'(bus.strike), 0);
        @(negedge clk);
        bus.wire_cut = 4'b0010;
        waitn(6);
        chk("strike_set", int'(bus.strike), 1);
        chk("strike_still_run", int'(bus.state), int'(RUN));
        @(negedge clk);
        bus.wire_cut = 4'b1010; stamp = cyc;
        push(BOOM, 1, 0, 0, 0, 1, exp_score, 3, -1);
        drain(10, "strike_boom");
        waitn(220);
        bus.wire_cut = 4'b0000; stamp = cyc;
        push(IDLE, 1, 0, 0, 0, 0, exp_score, 3, -1);
        drain(10, "strike_restore");
        arm(2'd0, exp_score);
        chk("strike_cleared", int'(bus.strike), 0);
        @(negedge clk);
        bus.power_sw = 1'b0; stamp = cyc;
        push(OFF, 0, 0, 0, 0, 0, exp_score, 3, -1);
        drain(10, "strike_off");
        @(negedge clk);
        bus.power_sw = 1'b1; stamp = cyc;
        push(IDLE, 1, 0, 0, 0, 0, exp_score, 3, -1);
        drain(10, "strike_on");
`endif

        // Defuse rounds with rotating key until score saturates
        for (int i = 0; i < 15; i++) begin
            logic [1:0] k;
            logic [3:0] w;
            k = 2'(i % 4);
            w = 4'b0001 << k;
            arm(k, exp_score);
            @(negedge clk);
            bus.wire_cut = w; stamp = cyc;
            if (exp_score != 4'd15) exp_score = exp_score + 4'd1;
            push(DEF, 1, 0, 0, 1, 0, exp_score, 3, -1);
            drain(10, "round_defuse");
            waitn(5);
            bus.wire_cut = 4'b0000;
            push(IDLE, 1, 0, 0, 0, 0, exp_score, -1, 200);
            drain(300, "round_hold");
        end

        waitn(5);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
